// File: rtl/rysy_pkg.sv
// Shared rysyCore types and constants: opcodes, datapath select codes,
// sequencer state encoding and the decode payload carried from ctrl_decode.
package rysy_pkg;

  localparam int unsigned NOP_SLOTS_DEF = 1;
  localparam int unsigned TIMEOUT_DEF   = 16;

  typedef enum logic [2:0] {
    RUN     = 3'd0,
    LD_WAIT = 3'd1,
    LD_WB   = 3'd2,
    ST_WAIT = 3'd3,
    FLUSH   = 3'd4,
    ERR     = 3'd5
  } state_t;

  // instr[6:2] opcodes
  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_OP_IMM = 5'b00100;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_JAL    = 5'b11011;

  localparam logic [6:0] F7_ALT = 7'b0100000;

  localparam logic [1:0] PC_P4  = 2'd0;
  localparam logic [1:0] PC_ALU = 2'd1;
  localparam logic [1:0] PC_OLD = 2'd2;

  localparam logic [1:0] INST_MEM = 2'd0;
  localparam logic [1:0] INST_NOP = 2'd1;
  localparam logic [1:0] INST_OLD = 2'd2;

  localparam logic MEM_PC  = 1'b0;
  localparam logic MEM_ALU = 1'b1;

  localparam logic [1:0] RD_ALU = 2'd0;
  localparam logic [1:0] RD_MEM = 2'd1;
  localparam logic [1:0] RD_PC4 = 2'd2;
  localparam logic [1:0] RD_IMM = 2'd3;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic ALU1_RS1 = 1'b0;
  localparam logic ALU1_PC  = 1'b1;
  localparam logic ALU2_RS2 = 1'b0;
  localparam logic ALU2_IMM = 1'b1;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  // cmp_op and sel_type carry func3 unchanged (BEQ..BGEU, LB..LHU/SB..SW)
  typedef struct packed {
    logic [2:0] imm_type;
    logic       alu1_sel;
    logic       alu2_sel;
    logic [1:0] rd_sel;
    logic [2:0] cmp_op;
    logic [2:0] sel_type;
    logic [3:0] alu_op;
  } dec_t;

endpackage

// File: rtl/ctrl_decode.sv
// Stateless RV32I field decode: immediate type, ALU operands/op, compare,
// load/store width select and rd source, all zero-latency from the opcode.
module ctrl_decode
  import rysy_pkg::*;
(
  input  logic [4:0] opcode,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  output dec_t       dec
);

  logic       alt;
  logic [3:0] alu_fn;

  // func7 = 0100000 selects SUB (register form only) and SRA/SRAI
  assign alt = (func7 == F7_ALT);

  always_comb begin
    alu_fn = ALU_ADD;
    case (func3)
      3'b000:  alu_fn = (alt && opcode == OPC_OP) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_fn = ALU_SLL;
      3'b010:  alu_fn = ALU_SLT;
      3'b011:  alu_fn = ALU_SLTU;
      3'b100:  alu_fn = ALU_XOR;
      3'b101:  alu_fn = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_fn = ALU_OR;
      default: alu_fn = ALU_AND;
    endcase
  end

  always_comb begin
    dec.imm_type = IMM_I;
    dec.alu1_sel = ALU1_RS1;
    dec.alu2_sel = ALU2_IMM;
    dec.rd_sel   = RD_ALU;
    dec.cmp_op   = func3;
    dec.sel_type = func3;
    dec.alu_op   = ALU_ADD;
    case (opcode)
      OPC_OP: begin
        dec.alu2_sel = ALU2_RS2;
        dec.alu_op   = alu_fn;
      end
      OPC_OP_IMM: dec.alu_op = alu_fn;
      OPC_LUI: begin
        dec.imm_type = IMM_U;
        dec.rd_sel   = RD_IMM;
      end
      OPC_JAL: begin
        dec.imm_type = IMM_J;
        dec.alu1_sel = ALU1_PC;
        dec.rd_sel   = RD_PC4;
      end
      OPC_JALR: dec.rd_sel = RD_PC4;
      OPC_BRANCH: begin
        dec.imm_type = IMM_B;
        dec.alu1_sel = ALU1_PC;
      end
      OPC_LOAD:  dec.rd_sel   = RD_MEM;
      OPC_STORE: dec.imm_type = IMM_S;
      default: ;
    endcase
  end

endmodule

// File: rtl/ctrl_seq.sv
// Multi-cycle control sequencer with req/ack data memory, wait timeout and
// post-transfer flush bubbles. Define CTRL_ILLEGAL_TRAP_EN to trap unknown opcodes.
module ctrl_seq
  import rysy_pkg::*;
#(
  parameter int unsigned NOP_SLOTS = NOP_SLOTS_DEF,
  parameter int unsigned TIMEOUT   = TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] opcode,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  input  logic       b,
  input  logic       dmem_ack,
  output logic       dmem_req,
  output logic       reg_wr,
  output logic       we,
  output logic [2:0] imm_type,
  output logic [2:0] cmp_op,
  output logic [2:0] sel_type,
  output logic       alu1_sel,
  output logic       alu2_sel,
  output logic [1:0] rd_sel,
  output logic [1:0] pc_sel,
  output logic [1:0] inst_sel,
  output logic       mem_sel,
  output logic [3:0] alu_op,
  output logic       busy,
  output logic       err
);

  localparam int unsigned FCNT_W = 2;
  localparam int unsigned WCNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [FCNT_W-1:0] FLUSH_LOAD = FCNT_W'(NOP_SLOTS - 1);

  state_t            state, state_nx;
  logic [FCNT_W-1:0] fcnt, fcnt_nx;
  logic [WCNT_W-1:0] wcnt, wcnt_nx, wcnt_inc;
  logic              timeout_hit;
  dec_t              dec;

  ctrl_decode u_decode (
    .opcode (opcode),
    .func3  (func3),
    .func7  (func7),
    .dec    (dec)
  );

  assign imm_type = dec.imm_type;
  assign alu1_sel = dec.alu1_sel;
  assign alu2_sel = dec.alu2_sel;
  assign rd_sel   = dec.rd_sel;
  assign cmp_op   = dec.cmp_op;
  assign sel_type = dec.sel_type;
  assign alu_op   = dec.alu_op;

  // Saturating wait count; reaching TIMEOUT without ack is a bus error
  assign wcnt_inc    = (wcnt == '1) ? wcnt : wcnt + WCNT_W'(1);
  assign timeout_hit = (TIMEOUT > 0) && (wcnt_inc == WCNT_W'(TIMEOUT));

  // Reset lands in a single-bubble FLUSH so the first fetch is not executed twice
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FLUSH;
      fcnt  <= '0;
      wcnt  <= '0;
    end else begin
      state <= state_nx;
      fcnt  <= fcnt_nx;
      wcnt  <= wcnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    fcnt_nx  = fcnt;
    wcnt_nx  = wcnt;
    reg_wr   = 1'b0;
    we       = 1'b0;
    dmem_req = 1'b0;
    pc_sel   = PC_P4;
    inst_sel = INST_MEM;
    mem_sel  = MEM_PC;
    busy     = (state != RUN);
    err      = 1'b0;

    case (state)
      RUN: begin
        fcnt_nx = FLUSH_LOAD;
        case (opcode)
          OPC_OP, OPC_OP_IMM, OPC_LUI: reg_wr = 1'b1;
          OPC_JAL, OPC_JALR: begin
            reg_wr   = 1'b1;
            pc_sel   = PC_ALU;
            inst_sel = INST_NOP;
            state_nx = FLUSH;
          end
          OPC_BRANCH: begin
            if (b) begin
              pc_sel   = PC_ALU;
              inst_sel = INST_NOP;
              state_nx = FLUSH;
            end
          end
          OPC_LOAD: begin
            dmem_req = 1'b1;
            mem_sel  = MEM_ALU;
            pc_sel   = PC_OLD;
            inst_sel = INST_OLD;
            wcnt_nx  = '0;
            state_nx = dmem_ack ? LD_WB : LD_WAIT;
          end
          OPC_STORE: begin
            dmem_req = 1'b1;
            we       = 1'b1;
            mem_sel  = MEM_ALU;
            pc_sel   = PC_OLD;
            inst_sel = INST_OLD;
            wcnt_nx  = '0;
            state_nx = dmem_ack ? FLUSH : ST_WAIT;
          end
          default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
            pc_sel   = PC_OLD;
            inst_sel = INST_NOP;
            state_nx = ERR;
`else
            pc_sel   = PC_P4;
            inst_sel = INST_MEM;
`endif
          end
        endcase
      end
      LD_WAIT, ST_WAIT: begin
        dmem_req = 1'b1;
        we       = (state == ST_WAIT);
        mem_sel  = MEM_ALU;
        pc_sel   = PC_OLD;
        inst_sel = INST_OLD;
        fcnt_nx  = FLUSH_LOAD;
        if (dmem_ack) begin
          state_nx = (state == LD_WAIT) ? LD_WB : FLUSH;
        end else begin
          wcnt_nx = wcnt_inc;
          if (timeout_hit) state_nx = ERR;
        end
      end
      LD_WB: begin
        reg_wr   = 1'b1;
        inst_sel = INST_NOP;
        state_nx = RUN;
      end
      FLUSH: begin
        inst_sel = INST_NOP;
        if (fcnt == '0) state_nx = RUN;
        else            fcnt_nx  = fcnt - FCNT_W'(1);
      end
      ERR: begin
        pc_sel   = PC_OLD;
        inst_sel = INST_NOP;
        err      = 1'b1;
      end
      default: state_nx = ERR;
    endcase

    // Reset forces a safe, write-free output set and abandons any request
    if (rst) begin
      reg_wr   = 1'b0;
      we       = 1'b0;
      dmem_req = 1'b0;
      err      = 1'b0;
      busy     = 1'b1;
      pc_sel   = PC_OLD;
      inst_sel = INST_NOP;
      mem_sel  = MEM_PC;
    end
  end

endmodule

// File: tb/tb_ctrl_seq.sv
// Scoreboard bench for ctrl_seq (NOP_SLOTS=3, TIMEOUT=8): directed vectors push
// hand-written expected outputs; a negedge monitor pops and compares.
module tb_ctrl_seq;
  import rysy_pkg::*;

  typedef struct packed {
    logic       reg_wr;
    logic       we;
    logic       req;
    logic [1:0] pc;
    logic [1:0] inst;
    logic       mem;
    logic       busy;
    logic       err;
  } ctl_t;

  typedef struct packed {
    logic       chk;
    logic [2:0] imm;
    logic       a2;
    logic [1:0] rd;
    logic [3:0] alu;
  } dexp_t;

  typedef struct packed {
    int    idx;
    ctl_t  ctl;
    dexp_t d;
  } sb_t;

  localparam ctl_t C_RST = '{1'b0, 1'b0, 1'b0, PC_OLD, INST_NOP, MEM_PC, 1'b1, 1'b0};
  localparam ctl_t C_FLS = '{1'b0, 1'b0, 1'b0, PC_P4, INST_NOP, MEM_PC, 1'b1, 1'b0};
  localparam ctl_t C_ALU = '{1'b1, 1'b0, 1'b0, PC_P4, INST_MEM, MEM_PC, 1'b0, 1'b0};
  localparam ctl_t C_NOP = '{1'b0, 1'b0, 1'b0, PC_P4, INST_MEM, MEM_PC, 1'b0, 1'b0};
  localparam ctl_t C_JMP = '{1'b1, 1'b0, 1'b0, PC_ALU, INST_NOP, MEM_PC, 1'b0, 1'b0};
  localparam ctl_t C_BR  = '{1'b0, 1'b0, 1'b0, PC_ALU, INST_NOP, MEM_PC, 1'b0, 1'b0};
  localparam ctl_t C_LD0 = '{1'b0, 1'b0, 1'b1, PC_OLD, INST_OLD, MEM_ALU, 1'b0, 1'b0};
  localparam ctl_t C_LD1 = '{1'b0, 1'b0, 1'b1, PC_OLD, INST_OLD, MEM_ALU, 1'b1, 1'b0};
  localparam ctl_t C_ST0 = '{1'b0, 1'b1, 1'b1, PC_OLD, INST_OLD, MEM_ALU, 1'b0, 1'b0};
  localparam ctl_t C_ST1 = '{1'b0, 1'b1, 1'b1, PC_OLD, INST_OLD, MEM_ALU, 1'b1, 1'b0};
  localparam ctl_t C_WB  = '{1'b1, 1'b0, 1'b0, PC_P4, INST_NOP, MEM_PC, 1'b1, 1'b0};
  localparam ctl_t C_ERR = '{1'b0, 1'b0, 1'b0, PC_OLD, INST_NOP, MEM_PC, 1'b1, 1'b1};
  localparam dexp_t ND   = '0;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] opcode = OPC_OP_IMM;
  logic [2:0] func3 = 3'd0;
  logic [6:0] func7 = 7'd0;
  logic       b = 1'b0;
  logic       dmem_ack = 1'b0;
  logic       dmem_req, reg_wr, we, alu1_sel, alu2_sel, mem_sel, busy, err;
  logic [2:0] imm_type, cmp_op, sel_type;
  logic [1:0] rd_sel, pc_sel, inst_sel;
  logic [3:0] alu_op;

  sb_t sb[$];
  int  checks = 0;
  int  errors = 0;
  int  step_no = 0;
  bit  done = 1'b0;

  always #5 clk = ~clk;

  ctrl_seq #(.NOP_SLOTS(3), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .func7(func7),
    .b(b), .dmem_ack(dmem_ack), .dmem_req(dmem_req), .reg_wr(reg_wr), .we(we),
    .imm_type(imm_type), .cmp_op(cmp_op), .sel_type(sel_type),
    .alu1_sel(alu1_sel), .alu2_sel(alu2_sel), .rd_sel(rd_sel), .pc_sel(pc_sel),
    .inst_sel(inst_sel), .mem_sel(mem_sel), .alu_op(alu_op), .busy(busy), .err(err)
  );

  function automatic dexp_t dx(input logic [2:0] imm, input logic a2,
                               input logic [1:0] rd, input logic [3:0] alu);
    return '{1'b1, imm, a2, rd, alu};
  endfunction

  task automatic cyc(input logic [4:0] op, input logic [2:0] f3, input logic [6:0] f7,
                     input logic bb, input logic ack, input logic r,
                     input ctl_t c, input dexp_t d);
    sb_t e;
    @(posedge clk);
    #1;
    opcode = op; func3 = f3; func7 = f7; b = bb; dmem_ack = ack; rst = r;
    step_no++;
    e.idx = step_no;
    e.ctl = c;
    e.d   = d;
    sb.push_back(e);
  endtask

  task automatic run(input logic [4:0] op, input logic ack, input ctl_t c);
    cyc(op, 3'd0, 7'd0, 1'b0, ack, 1'b0, c, ND);
  endtask

  // Monitor: one expected record per cycle, compared away from the active edge
  always @(negedge clk) begin
    sb_t  e;
    ctl_t act;
    logic [9:0] act_d, exp_d;
    if (sb.size() > 0 && !done) begin
      e = sb.pop_front();
      act = '{reg_wr, we, dmem_req, pc_sel, inst_sel, mem_sel, busy, err};
      checks++;
      if (act !== e.ctl) begin
        errors++;
        $display("FAIL ctl step %0d: got wr/we/req/pc/inst/mem/busy/err=%b expected %b",
                 e.idx, act, e.ctl);
      end
      if (e.d.chk) begin
        act_d = {imm_type, alu2_sel, rd_sel, alu_op};
        exp_d = {e.d.imm, e.d.a2, e.d.rd, e.d.alu};
        checks++;
        if (act_d !== exp_d) begin
          errors++;
          $display("FAIL decode step %0d: got imm/a2/rd/alu=%b expected %b", e.idx, act_d, exp_d);
        end
      end
    end else if (done && sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expected records never compared", sb.size());
      sb.delete();
    end
  end

  initial begin
    // Reset held, then the single post-reset bubble, then a 1-cycle ALU stream
    cyc(OPC_OP_IMM, 3'd0, 7'd0, 1'b0, 1'b0, 1'b1, C_RST, ND);
    cyc(OPC_OP_IMM, 3'd0, 7'd0, 1'b0, 1'b1, 1'b1, C_RST, ND);
    run(OPC_OP_IMM, 1'b0, C_FLS);
    cyc(OPC_OP_IMM, 3'b000, 7'b0100000, 1'b0, 1'b0, 1'b0, C_ALU, dx(IMM_I, ALU2_IMM, RD_ALU, ALU_ADD));
    cyc(OPC_OP_IMM, 3'b101, 7'b0100000, 1'b0, 1'b0, 1'b0, C_ALU, dx(IMM_I, ALU2_IMM, RD_ALU, ALU_SRA));
    cyc(OPC_OP, 3'b000, 7'b0100000, 1'b0, 1'b0, 1'b0, C_ALU, dx(IMM_I, ALU2_RS2, RD_ALU, ALU_SUB));
    cyc(OPC_OP, 3'b111, 7'b0000000, 1'b0, 1'b0, 1'b0, C_ALU, dx(IMM_I, ALU2_RS2, RD_ALU, ALU_AND));
    cyc(OPC_LUI, 3'b000, 7'b0000000, 1'b0, 1'b0, 1'b0, C_ALU, dx(IMM_U, ALU2_IMM, RD_IMM, ALU_ADD));
    run(OPC_OP_IMM, 1'b1, C_ALU);

    // Taken transfers: one cycle then NOP_SLOTS=3 bubbles
    cyc(OPC_JAL, 3'd0, 7'd0, 1'b0, 1'b0, 1'b0, C_JMP, dx(IMM_J, ALU2_IMM, RD_PC4, ALU_ADD));
    repeat (3) run(OPC_OP_IMM, 1'b0, C_FLS);
    run(OPC_OP_IMM, 1'b0, C_ALU);
    cyc(OPC_BRANCH, 3'd0, 7'd0, 1'b0, 1'b0, 1'b0, C_NOP, dx(IMM_B, ALU2_IMM, RD_ALU, ALU_ADD));
    cyc(OPC_BRANCH, 3'd0, 7'd0, 1'b1, 1'b0, 1'b0, C_BR, ND);
    repeat (3) run(OPC_OP_IMM, 1'b0, C_FLS);
    cyc(OPC_JALR, 3'd0, 7'd0, 1'b0, 1'b0, 1'b0, C_JMP, dx(IMM_I, ALU2_IMM, RD_PC4, ALU_ADD));
    repeat (3) run(OPC_OP_IMM, 1'b0, C_FLS);

    // Load, ack on the 4th wait cycle: req high 5 cycles, then write-back
    cyc(OPC_LOAD, 3'd0, 7'd0, 1'b0, 1'b0, 1'b0, C_LD0, dx(IMM_I, ALU2_IMM, RD_MEM, ALU_ADD));
    repeat (3) run(OPC_LOAD, 1'b0, C_LD1);
    run(OPC_LOAD, 1'b1, C_LD1);
    cyc(OPC_LOAD, 3'd0, 7'd0, 1'b0, 1'b1, 1'b0, C_WB, dx(IMM_I, ALU2_IMM, RD_MEM, ALU_ADD));
    run(OPC_OP_IMM, 1'b0, C_ALU);
    // Load with same-cycle ack
    run(OPC_LOAD, 1'b1, C_LD0);
    run(OPC_LOAD, 1'b0, C_WB);
    run(OPC_OP_IMM, 1'b0, C_ALU);

    // Stores: same-cycle ack and two wait cycles, each followed by 3 bubbles
    cyc(OPC_STORE, 3'b010, 7'd0, 1'b0, 1'b1, 1'b0, C_ST0, dx(IMM_S, ALU2_IMM, RD_ALU, ALU_ADD));
    repeat (3) run(OPC_OP_IMM, 1'b0, C_FLS);
    run(OPC_STORE, 1'b0, C_ST0);
    run(OPC_STORE, 1'b0, C_ST1);
    run(OPC_STORE, 1'b1, C_ST1);
    repeat (3) run(OPC_OP_IMM, 1'b1, C_FLS);
    run(OPC_OP_IMM, 1'b0, C_ALU);

    // Ack arriving on the 8th wait cycle beats the timeout
    run(OPC_LOAD, 1'b0, C_LD0);
    repeat (7) run(OPC_LOAD, 1'b0, C_LD1);
    run(OPC_LOAD, 1'b1, C_LD1);
    run(OPC_LOAD, 1'b0, C_WB);
    run(OPC_OP_IMM, 1'b0, C_ALU);

    // Unlisted opcode
`ifdef CTRL_ILLEGAL_TRAP_EN
    run(5'b11111, 1'b0, '{1'b0, 1'b0, 1'b0, PC_OLD, INST_NOP, MEM_PC, 1'b0, 1'b0});
    run(OPC_OP_IMM, 1'b0, C_ERR);
    cyc(OPC_OP_IMM, 3'd0, 7'd0, 1'b0, 1'b0, 1'b1, C_RST, ND);
    run(OPC_OP_IMM, 1'b0, C_FLS);
`else
    run(5'b11111, 1'b0, C_NOP);
`endif
    run(OPC_OP_IMM, 1'b0, C_ALU);

    // Reset during a load wait drops req immediately
    run(OPC_LOAD, 1'b0, C_LD0);
    run(OPC_LOAD, 1'b0, C_LD1);
    cyc(OPC_LOAD, 3'd0, 7'd0, 1'b0, 1'b1, 1'b1, C_RST, ND);
    run(OPC_OP_IMM, 1'b0, C_FLS);
    run(OPC_OP_IMM, 1'b0, C_ALU);

    // Timeout: 8 waits without ack -> sticky ERR, cleared only by rst
    run(OPC_LOAD, 1'b0, C_LD0);
    repeat (8) run(OPC_LOAD, 1'b0, C_LD1);
    repeat (3) run(OPC_OP, 1'b1, C_ERR);
    cyc(OPC_OP, 3'd0, 7'd0, 1'b0, 1'b0, 1'b1, C_RST, ND);
    run(OPC_OP_IMM, 1'b0, C_FLS);
    run(OPC_OP_IMM, 1'b0, C_ALU);
    run(OPC_OP_IMM, 1'b0, C_ALU);

    repeat (2) @(posedge clk);
    done = 1'b1;
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
